// File: rtl/afp3_ram_sdp_pkg.sv
// Shared definitions for the afp3 simple-dual-port RAM macro.
//   COLL_READ_OLD / COLL_WRITE_THROUGH : collision-mode encodings
//   init_state_e                       : INIT/RUN state of the clear sequencer
//   clog2_min1                         : address width, never below 1 bit
package afp3_ram_pkg;

  localparam int COLL_READ_OLD      = 0;
  localparam int COLL_WRITE_THROUGH = 1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } init_state_e;

  // A one-word RAM still needs a 1-bit address port.
  function automatic int clog2_min1(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/afp3_ram_sdp_if.sv
// Bus bundle for afp3_ram_sdp.
//   master : drives wren/wrad/wrmask/data and rden/rdad, receives q/q_vld/init_done
//   slave  : the RAM side
// Handshake: there is no ready. A request (wren or rden) is taken on the
// rising edge where it is high and init_done is high; otherwise it is
// dropped. q_vld is a one-cycle strobe per accepted read and must be
// consumed in that cycle. dbg_state exposes the init sequencer state.
interface afp3_ram_sdp_if #(
  parameter int WIDTH  = 4,
  parameter int LANE_W = 4,
  parameter int AW     = 10
);
  import afp3_ram_pkg::*;

  localparam int LANES = WIDTH / LANE_W;

  logic             wren;
  logic [AW-1:0]    wrad;
  logic [LANES-1:0] wrmask;
  logic [WIDTH-1:0] data;
  logic             rden;
  logic [AW-1:0]    rdad;
  logic [WIDTH-1:0] q;
  logic             q_vld;
  logic             init_done;
  init_state_e      dbg_state;

  modport master (
    output wren, wrad, wrmask, data, rden, rdad,
    input  q, q_vld, init_done, dbg_state
  );

  modport slave (
    input  wren, wrad, wrmask, data, rden, rdad,
    output q, q_vld, init_done, dbg_state
  );

endinterface

// File: rtl/afp3_ram_sdp_init_seq.sv
// Post-reset clear sequencer. In INIT it emits one all-zero write per cycle
// to addresses 0..DEPTH-1, then parks in RUN with init_done high until the
// next reset.
//   clk, reset    : clock, synchronous active-high reset
//   o_init_we     : clear-write strobe (takes priority over user writes)
//   o_init_ad     : clear-write address
//   o_init_done   : block accepts user traffic
//   o_state       : current FSM state (debug)
module afp3_ram_sdp_init_seq
  import afp3_ram_pkg::*;
#(
  parameter int DEPTH         = 1024,
  parameter int AW            = 10,
  parameter int INIT_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic          o_init_we,
  output logic [AW-1:0] o_init_ad,
  output logic          o_init_done,
  output init_state_e   o_state
);

  localparam logic [AW-1:0] LAST_AD = AW'(DEPTH - 1);

  init_state_e   r_state;
  init_state_e   w_state_nxt;
  logic [AW-1:0] r_init_cnt;
  logic [AW-1:0] w_cnt_nxt;
  logic          r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= (INIT_ON_RESET != 0) ? INIT : RUN;
      r_init_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_cnt_nxt;
      // Registered so init_done is low through reset even when the FSM
      // resets straight into RUN.
      r_done     <= (w_state_nxt == RUN);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_init_cnt;
    o_init_we   = 1'b0;
    case (r_state)
      INIT: begin
        // Gated by reset so an interrupted clear never writes on the reset edge.
        o_init_we = !reset;
        if (r_init_cnt == LAST_AD) w_state_nxt = RUN;
        else                       w_cnt_nxt   = r_init_cnt + 1'b1;
      end
      RUN: ;
      default: w_state_nxt = INIT;
    endcase
  end

  assign o_init_ad   = r_init_cnt;
  assign o_init_done = r_done;
  assign o_state     = r_state;

endmodule

// File: rtl/afp3_ram_sdp.sv
// Parametrised 1W/1R block RAM with per-lane write mask, defined collision
// result, optional output register and optional post-reset clear.
//   clk, reset : clock, synchronous active-high reset
//   bus        : afp3_ram_sdp_if.slave (write port, read port, q/q_vld,
//                init_done, debug state)
// Read pipeline: edge N captures the array (old contents) plus the collision
// info; edge N+1 applies the bypass merge into q; OUT_REG adds edge N+2.
module afp3_ram_sdp
  import afp3_ram_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int DEPTH          = 1024,
  parameter int LANE_W         = 4,
  parameter int OUT_REG        = 0,
  parameter int COLLISION_MODE = 0,
  parameter int INIT_ON_RESET  = 1
) (
  input  logic           clk,
  input  logic           reset,
  afp3_ram_sdp_if.slave  bus
);

  localparam int LANES = WIDTH / LANE_W;
  localparam int AW    = clog2_min1(DEPTH);

  (* ram_style = "block" *) logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_init_we;
  logic [AW-1:0]    w_init_ad;
  logic             w_init_done;
  logic             w_wr_in_range;
  logic             w_rd_in_range;
  logic             w_usr_we;
  logic             w_usr_re;
  logic             w_we;
  logic [AW-1:0]    w_ad;
  logic [WIDTH-1:0] w_wdata;
  logic [LANES-1:0] w_wmask;

  afp3_ram_sdp_init_seq #(
    .DEPTH         (DEPTH),
    .AW            (AW),
    .INIT_ON_RESET (INIT_ON_RESET)
  ) u_init_seq (
    .clk         (clk),
    .reset       (reset),
    .o_init_we   (w_init_we),
    .o_init_ad   (w_init_ad),
    .o_init_done (w_init_done),
    .o_state     (bus.dbg_state)
  );

  // Address range checks only exist when DEPTH leaves unused codes.
  if (DEPTH == (1 << AW)) begin : g_pow2
    assign w_wr_in_range = 1'b1;
    assign w_rd_in_range = 1'b1;
  end else begin : g_npow2
    localparam logic [AW-1:0] DEPTH_AW = AW'(DEPTH);
    assign w_wr_in_range = (bus.wrad < DEPTH_AW);
    assign w_rd_in_range = (bus.rdad < DEPTH_AW);
  end

  assign w_usr_we = w_init_done & bus.wren & w_wr_in_range;
  assign w_usr_re = w_init_done & bus.rden;

  // Clear writes and user writes are mutually exclusive in time; the
  // clear sequencer owns the port until init_done.
  always_comb begin
    w_we    = w_init_we | w_usr_we;
    w_ad    = w_init_we ? w_init_ad : bus.wrad;
    w_wdata = w_init_we ? '0        : bus.data;
    w_wmask = w_init_we ? '1        : bus.wrmask;
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_wmask[i]) r_mem[w_ad][i*LANE_W +: LANE_W] <= w_wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  // Stage 1: array read (pre-write contents) and registered collision compare.
  logic             r_rd_vld1;
  logic [WIDTH-1:0] r_rd_data1;
  logic             r_coll;
  logic [WIDTH-1:0] r_coll_data;
  logic [LANES-1:0] r_coll_mask;
  logic [WIDTH-1:0] w_rd_result;

  always_ff @(posedge clk) begin
    if (reset) r_rd_vld1 <= 1'b0;
    else       r_rd_vld1 <= w_usr_re;
  end

  always_ff @(posedge clk) begin
    if (w_usr_re) begin
      r_rd_data1  <= w_rd_in_range ? r_mem[bus.rdad] : '0;
      r_coll      <= w_usr_we && (bus.wrad == bus.rdad);
      r_coll_data <= bus.data;
      r_coll_mask <= bus.wrmask;
    end
  end

  // Write-through bypass: masked lanes take the colliding write data.
  always_comb begin
    w_rd_result = r_rd_data1;
    if (COLLISION_MODE == COLL_WRITE_THROUGH && r_coll) begin
      for (int i = 0; i < LANES; i++) begin
        if (r_coll_mask[i]) w_rd_result[i*LANE_W +: LANE_W] = r_coll_data[i*LANE_W +: LANE_W];
      end
    end
  end

  // Stage 2: q register, only loaded on a valid result so it holds between reads.
  logic             r_q2_vld;
  logic [WIDTH-1:0] r_q2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q2_vld <= 1'b0;
      r_q2     <= '0;
    end else begin
      r_q2_vld <= r_rd_vld1;
      if (r_rd_vld1) r_q2 <= w_rd_result;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic             r_q3_vld;
    logic [WIDTH-1:0] r_q3;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_q3_vld <= 1'b0;
        r_q3     <= '0;
      end else begin
        r_q3_vld <= r_q2_vld;
        if (r_q2_vld) r_q3 <= r_q2;
      end
    end

    assign bus.q     = r_q3;
    assign bus.q_vld = r_q3_vld;
  end else begin : g_no_out_reg
    assign bus.q     = r_q2;
    assign bus.q_vld = r_q2_vld;
  end

  assign bus.init_done = w_init_done;

endmodule

// File: tb/tb_afp3_ram_sdp.sv
// Bench for afp3_ram_sdp. Two instances share one stimulus stream:
//   A: WIDTH=16 DEPTH=600  OUT_REG=0 read-old
//   B: WIDTH=16 DEPTH=1024 OUT_REG=1 write-through
module tb_afp3_ram_sdp;

  localparam int W       = 16;
  localparam int AW      = 10;
  localparam int DEPTH_A = 600;
  localparam int DEPTH_B = 1024;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  afp3_ram_sdp_if #(.WIDTH(W), .LANE_W(4), .AW(AW)) bus_a ();
  afp3_ram_sdp_if #(.WIDTH(W), .LANE_W(4), .AW(AW)) bus_b ();

  afp3_ram_sdp #(.WIDTH(W), .DEPTH(DEPTH_A), .LANE_W(4), .OUT_REG(0),
                 .COLLISION_MODE(0), .INIT_ON_RESET(1))
    u_a (.clk(clk), .reset(reset), .bus(bus_a));

  afp3_ram_sdp #(.WIDTH(W), .DEPTH(DEPTH_B), .LANE_W(4), .OUT_REG(1),
                 .COLLISION_MODE(1), .INIT_ON_RESET(1))
    u_b (.clk(clk), .reset(reset), .bus(bus_b));

  // ---------------- reference model state ----------------
  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t         exp_qa[$];
  exp_t         exp_qb[$];
  logic [W-1:0] mm_a [DEPTH_A];
  logic [W-1:0] mm_b [DEPTH_B];
  logic [W-1:0] last_a = '0;
  logic [W-1:0] last_b = '0;
  int           cyc = 0;          // rising edges seen so far
  int           rel = 0;          // index of last edge with reset high
  bit           rst_at_edge = 1'b1;
  int           checks = 0;
  int           passes = 0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= reset;
    if (reset) rel <= cyc + 1;
  end

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] nw,
                                         input logic [3:0] m);
    logic [W-1:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[i*4 +: 4] = nw[i*4 +: 4];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  // ---------------- scoreboard (sampled on falling edge) ----------------
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (rst_at_edge) begin
        last_a = '0;
        last_b = '0;
      end
      check("a_init_done", 32'(bus_a.init_done), 32'(cyc >= rel + DEPTH_A));
      check("b_init_done", 32'(bus_b.init_done), 32'(cyc >= rel + DEPTH_B));

      if (bus_a.q_vld) begin
        if (exp_qa.size() != 0 && exp_qa[0].due == cyc) begin
          check("a_q", 32'(bus_a.q), 32'(exp_qa[0].data));
          last_a = exp_qa[0].data;
          void'(exp_qa.pop_front());
        end else check("a_q_vld", 32'(bus_a.q_vld), 32'd0);
      end else begin
        check("a_q_hold", 32'(bus_a.q), 32'(last_a));
        if (exp_qa.size() != 0 && exp_qa[0].due <= cyc) begin
          check("a_q_vld", 32'(bus_a.q_vld), 32'd1);
          void'(exp_qa.pop_front());
        end
      end

      if (bus_b.q_vld) begin
        if (exp_qb.size() != 0 && exp_qb[0].due == cyc) begin
          check("b_q", 32'(bus_b.q), 32'(exp_qb[0].data));
          last_b = exp_qb[0].data;
          void'(exp_qb.pop_front());
        end else check("b_q_vld", 32'(bus_b.q_vld), 32'd0);
      end else begin
        check("b_q_hold", 32'(bus_b.q), 32'(last_b));
        if (exp_qb.size() != 0 && exp_qb[0].due <= cyc) begin
          check("b_q_vld", 32'(bus_b.q_vld), 32'd1);
          void'(exp_qb.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Applies one cycle of inputs; the model decides acceptance from the
  // release edge and the depth, then records expected reads and writes.
  task automatic step(input bit we, input logic [9:0] wa, input logic [3:0] wm,
                      input logic [15:0] wd, input bit re, input logic [9:0] ra,
                      input bit use_exp, input logic [15:0] ea, input logic [15:0] eb);
    bit           ok_a;
    bit           ok_b;
    logic [W-1:0] v;
    ok_a = !reset && (cyc >= rel + DEPTH_A);
    ok_b = !reset && (cyc >= rel + DEPTH_B);
    bus_a.wren = we; bus_a.wrad = wa; bus_a.wrmask = wm; bus_a.data = wd;
    bus_a.rden = re; bus_a.rdad = ra;
    bus_b.wren = we; bus_b.wrad = wa; bus_b.wrmask = wm; bus_b.data = wd;
    bus_b.rden = re; bus_b.rdad = ra;
    // A: read-old, latency 1, out-of-range reads give zero
    if (ok_a && re) begin
      if (ra >= DEPTH_A) v = '0;
      else               v = mm_a[ra];
      exp_qa.push_back('{use_exp ? ea : v, cyc + 2});
    end
    if (ok_a && we && wa < DEPTH_A) mm_a[wa] = merge(mm_a[wa], wd, wm);
    // B: write-through on same-address collision, latency 2
    if (ok_b && re) begin
      v = mm_b[ra];
      if (we && wa == ra) v = merge(v, wd, wm);
      exp_qb.push_back('{use_exp ? eb : v, cyc + 3});
    end
    if (ok_b && we) mm_b[wa] = merge(mm_b[wa], wd, wm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  function automatic logic [9:0] rand_addr();
    if ($urandom_range(0, 3) == 3) return 10'($urandom_range(595, 615));
    return 10'($urandom_range(0, 7));
  endfunction

  task automatic rand_step(input bit wr_ok, input bit rd_ok);
    step(wr_ok && ($urandom_range(0, 1) == 1), rand_addr(), 4'($urandom_range(0, 15)),
         16'($urandom), rd_ok && ($urandom_range(0, 1) == 1), rand_addr(), 1'b0, '0, '0);
  endtask

  // Assert reset for n edges; on release the clear sequence zeroes both arrays.
  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) idle();
    reset = 1'b0;
    foreach (mm_a[i]) mm_a[i] = '0;
    foreach (mm_b[i]) mm_b[i] = '0;
  endtask

  task automatic drain();
    repeat (6) idle();
    check("a_drain", 32'(exp_qa.size()), 32'd0);
    check("b_drain", 32'(exp_qb.size()), 32'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          we;
    logic [9:0]  wa;
    logic [3:0]  wm;
    logic [15:0] wd;
    bit          re;
    logic [9:0]  ra;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;

  vec_t vt [20];

  initial begin
    vt[0]  = '{1'b0, 10'd0,     4'h0, 16'h0000, 1'b1, 10'h3FF, 16'h0000, 16'h0000};
    vt[1]  = '{1'b1, 10'd5,     4'hF, 16'h000A, 1'b0, 10'd0,   16'h0000, 16'h0000};
    vt[2]  = '{1'b0, 10'd0,     4'h0, 16'h0000, 1'b1, 10'd5,   16'h000A, 16'h000A};
    vt[3]  = '{1'b1, 10'd9,     4'hF, 16'h1234, 1'b0, 10'd0,   16'h0000, 16'h0000};
    vt[4]  = '{1'b1, 10'd9,     4'h5, 16'hABCD, 1'b0, 10'd0,   16'h0000, 16'h0000};
    vt[5]  = '{1'b0, 10'd0,     4'h0, 16'h0000, 1'b1, 10'd9,   16'h1B3D, 16'h1B3D};
    vt[6]  = '{1'b1, 10'd7,     4'hF, 16'h0003, 1'b0, 10'd0,   16'h0000, 16'h0000};
    vt[7]  = '{1'b1, 10'd7,     4'hF, 16'h000C, 1'b1, 10'd7,   16'h0003, 16'h000C};
    vt[8]  = '{1'b0, 10'd0,     4'h0, 16'h0000, 1'b1, 10'd7,   16'h000C, 16'h000C};
    vt[9]  = '{1'b1, 10'd7,     4'h6, 16'hFFFF, 1'b1, 10'd7,   16'h000C, 16'h0FFC};
    vt[10] = '{1'b0, 10'd0,     4'h0, 16'h0000, 1'b1, 10'd7,   16'h0FFC, 16'h0FFC};
    vt[11] = '{1'b1, 10'd610,   4'hF, 16'h5555, 1'b0, 10'd0,   16'h0000, 16'h0000};
    vt[12] = '{1'b0, 10'd0,     4'h0, 16'h0000, 1'b1, 10'd610, 16'h0000, 16'h5555};
    vt[13] = '{1'b1, 10'd599,   4'hF, 16'h0599, 1'b0, 10'd0,   16'h0000, 16'h0000};
    vt[14] = '{1'b0, 10'd0,     4'h0, 16'h0000, 1'b1, 10'd599, 16'h0599, 16'h0599};
    vt[15] = '{1'b0, 10'd0,     4'h0, 16'h0000, 1'b1, 10'd5,   16'h000A, 16'h000A};
    vt[16] = '{1'b1, 10'd5,     4'hF, 16'h00F0, 1'b1, 10'd5,   16'h000A, 16'h00F0};
    vt[17] = '{1'b0, 10'd0,     4'h0, 16'h0000, 1'b1, 10'd5,   16'h00F0, 16'h00F0};
    vt[18] = '{1'b1, 10'd5,     4'h0, 16'hFFFF, 1'b1, 10'd5,   16'h00F0, 16'h00F0};
    vt[19] = '{1'b0, 10'd0,     4'h0, 16'h0000, 1'b1, 10'd5,   16'h00F0, 16'h00F0};

    bus_a.wren = 1'b0; bus_a.wrad = '0; bus_a.wrmask = '0; bus_a.data = '0;
    bus_a.rden = 1'b0; bus_a.rdad = '0;
    bus_b.wren = 1'b0; bus_b.wrad = '0; bus_b.wrmask = '0; bus_b.data = '0;
    bus_b.rden = 1'b0; bus_b.rdad = '0;
    @(posedge clk);
    #1;

    // First clear: reads issued during INIT must be dropped.
    do_reset(3);
    repeat (DEPTH_B + 6) rand_step(1'b0, 1'b1);
    drain();

    // Directed vectors: latency, masking, collisions, range, back-to-back reads.
    for (int i = 0; i < 20; i++)
      step(vt[i].we, vt[i].wa, vt[i].wm, vt[i].wd, vt[i].re, vt[i].ra, 1'b1, vt[i].ea, vt[i].eb);
    drain();

    // Random traffic against the model (fills the memories with non-zero data).
    repeat (1500) rand_step(1'b1, 1'b1);
    drain();

    // Reset, then reset again at init cycle 300; traffic during INIT is dropped.
    do_reset(2);
    repeat (300) rand_step(1'b1, 1'b1);
    do_reset(3);
    repeat (590) rand_step(1'b1, 1'b1);
    repeat (DEPTH_B - 590 + 6) idle();

    // After the clear, old contents must read back as zero.
    repeat (400) rand_step(1'b1, 1'b1);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
